// File: rtl/rule110_snapshot_ser.sv
// Snapshot serializer for the rule 110 cell vector: captures q on start,
// streams it out lowest word first and reports the live-cell population.
// Ports: clk, reset (sync, active-high), q, start, out_data/out_valid/
// out_ready/out_last/out_index (stream), busy, pop_count/pop_valid.
module rule110_snapshot_ser #(
    parameter int WIDTH = 512,
    parameter int WORD = 32,
    localparam int NWORDS = WIDTH / WORD,
    localparam int CW = $clog2(WIDTH + 1),
    localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] q,
    input  logic             start,
    output logic [WORD-1:0]  out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [IW-1:0]    out_index,
    output logic             busy,
    output logic [CW-1:0]    pop_count,
    output logic             pop_valid
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

    state_t state;
    state_t state_n;

    logic [NWORDS-1:0][WORD-1:0] snap;
    logic [CW-1:0] acc;
    logic [CW-1:0] word_pop;
    logic [IW-1:0] next_index;
    logic          xfer;
    logic          at_last;

    assign xfer       = out_valid && out_ready;
    assign at_last    = (out_index == LAST_IDX);
    assign next_index = out_index + IW'(1);
    assign out_last   = out_valid && at_last;
    assign busy       = (state == SEND);

    // Population of the word currently on the bus.
    always_comb begin
        word_pop = '0;
        for (int i = 0; i < WORD; i++) begin
            word_pop = word_pop + CW'(out_data[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = SEND;
                end
            end
            SEND: begin
                if (xfer && at_last) begin
                    state_n = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            snap      <= '0;
            out_data  <= '0;
            out_index <= '0;
            out_valid <= 1'b0;
            acc       <= '0;
            pop_count <= '0;
            pop_valid <= 1'b0;
        end else begin
            pop_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        snap      <= q;
                        out_data  <= q[WORD-1:0];
                        out_index <= '0;
                        acc       <= '0;
                        out_valid <= 1'b1;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        if (at_last) begin
                            pop_count <= acc + word_pop;
                            pop_valid <= 1'b1;
                            out_valid <= 1'b0;
                        end else begin
                            // Stream from the shadow copy so q may keep evolving.
                            acc       <= acc + word_pop;
                            out_index <= next_index;
                            out_data  <= snap[next_index];
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rule110_snapshot_ser.sv
// Scoreboard testbench for rule110_snapshot_ser: stimulus pushes expected
// words and totals, a negedge monitor pops and compares them.
module tb_rule110_snapshot_ser;

    localparam int WIDTH = 512;
    localparam int WORD = 32;
    localparam int NW = WIDTH / WORD;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] q;
    logic             start;
    logic [WORD-1:0]  out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic [3:0]       out_index;
    logic             busy;
    logic [9:0]       pop_count;
    logic             pop_valid;

    rule110_snapshot_ser #(.WIDTH(WIDTH), .WORD(WORD)) dut (
        .clk(clk),
        .reset(reset),
        .q(q),
        .start(start),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last(out_last),
        .out_index(out_index),
        .busy(busy),
        .pop_count(pop_count),
        .pop_valid(pop_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_d[$];
    int          exp_i[$];
    int          pop_q[$];
    int          held = 0;

    logic        stalled = 1'b0;
    logic [31:0] prev_d;
    logic [3:0]  prev_i;

    function automatic void chk(input string nm,
                                input logic [63:0] act,
                                input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [WIDTH-1:0] rand_q();
        logic [WIDTH-1:0] v;
        for (int k = 0; k < NW; k++) v[k*WORD +: WORD] = $urandom;
        return v;
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (reset) begin
            stalled = 1'b0;
        end else begin
            chk("busy_vs_valid", 64'(busy), 64'(out_valid));
            if (stalled && out_valid) begin
                chk("hold_data", 64'(out_data), 64'(prev_d));
                chk("hold_index", 64'(out_index), 64'(prev_i));
            end
            if (out_valid && out_ready) begin
                if (exp_d.size() == 0) begin
                    chk("unexpected_word", 64'(out_data), 64'hdead);
                end else begin
                    automatic logic [31:0] ed = exp_d.pop_front();
                    automatic int ei = exp_i.pop_front();
                    chk("word_data", 64'(out_data), 64'(ed));
                    chk("word_index", 64'(out_index), 64'(ei));
                    chk("word_last", 64'(out_last), 64'(ei == NW - 1));
                end
            end
            stalled = out_valid && !out_ready;
            prev_d = out_data;
            prev_i = out_index;
            if (pop_valid) begin
                if (pop_q.size() == 0) begin
                    chk("unexpected_pop", 64'(pop_count), 64'hdead);
                end else begin
                    held = pop_q.pop_front();
                    chk("pop_count", 64'(pop_count), 64'(held));
                end
            end else begin
                chk("pop_hold", 64'(pop_count), 64'(held));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the start edge.
    task automatic start_xfer(input logic [WIDTH-1:0] qv);
        logic [WIDTH-1:0] sh;
        q = qv;
        start = 1'b1;
        for (int k = 0; k < NW; k++) begin
            sh = qv >> (k * WORD);
            exp_d.push_back(sh[31:0]);
            exp_i.push_back(k);
        end
        pop_q.push_back($countones(qv));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Returns at posedge+1 of the cycle where pop_valid is high.
    task automatic wait_done(input bit rnd_ready);
        int cyc = 0;
        while (!pop_valid && cyc < 400) begin
            out_ready = rnd_ready ? 1'($urandom % 2) : 1'b1;
            q = rand_q();
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!pop_valid) chk("done_timeout", 64'(cyc), 64'(0));
    endtask

    task automatic step(input logic rdy, input int n);
        for (int i = 0; i < n; i++) begin
            out_ready = rdy;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [WIDTH-1:0] v;
        reset = 1'b1;
        start = 1'b1;
        out_ready = 1'b1;
        q = rand_q();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_pop_valid", 64'(pop_valid), 64'(0));
        chk("rst_pop_count", 64'(pop_count), 64'(0));
        chk("rst_out_index", 64'(out_index), 64'(0));
        reset = 1'b0;
        start = 1'b0;
        step(1'b1, 2);

        start_xfer({WIDTH{1'b1}});
        wait_done(1'b0);
        step(1'b1, 1);
        chk("busy_after_done", 64'(busy), 64'(0));

        v = '0;
        v[0] = 1'b1;
        start_xfer(v);
        wait_done(1'b0);
        step(1'b1, 1);
        start_xfer({64{8'hA5}});
        wait_done(1'b0);
        step(1'b1, 1);

        v = '0;
        for (int k = 0; k < NW; k++) v[k*WORD +: WORD] = 32'(k);
        start_xfer(v);
        wait_done(1'b1);
        step(1'b0, 1);

        // start during SEND is ignored; reset aborts mid-stream
        start_xfer(rand_q());
        step(1'b1, 3);
        out_ready = 1'b0;
        q = rand_q();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        step(1'b1, 2);
        chk("index_before_abort", 64'(out_index), 64'(5));
        out_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'(0));
        chk("abort_pop_valid", 64'(pop_valid), 64'(0));
        chk("abort_pop_count", 64'(pop_count), 64'(0));
        reset = 1'b0;
        exp_d.delete();
        exp_i.delete();
        pop_q.delete();
        held = 0;
        step(1'b0, 1);
        start_xfer(rand_q());
        chk("restart_index", 64'(out_index), 64'(0));
        wait_done(1'b1);

        // back-to-back captures, started in the pop_valid cycle
        for (int t = 0; t < 4; t++) begin
            start_xfer(rand_q());
            chk("chain_first_valid", 64'(out_valid), 64'(1));
            wait_done(1'b1);
        end
        step(1'b1, 3);

        chk("words_drained", 64'(exp_d.size()), 64'(0));
        chk("pops_drained", 64'(pop_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rule110_snapshot_ser.md
Name: rule110_snapshot_ser

Overview:
Downstream consumer of the 512-cell rule 110 automaton register. On request it captures the current generation vector into a shadow register. It then streams the snapshot out as WORD-bit words over a valid/ready interface, lowest word first. While streaming it accumulates the live-cell population and reports the total once the last word is accepted. The automaton keeps evolving during a transfer; the stream always reflects the captured generation.

Parameters:
WIDTH, 512, number of cells in the automaton vector (q width).
WORD, 32, output word width; WIDTH must be an integer multiple of WORD.
NWORDS, WIDTH/WORD (derived, 16), number of words per snapshot.
CW, $clog2(WIDTH+1) (derived, 10), population count width.

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
q  input  WIDTH  current automaton state from the rule 110 stage
start  input  1  capture request; honoured only when idle
out_data  output  WORD  current stream word
out_valid  output  1  out_data is valid
out_ready  input  1  consumer accepts word when out_valid && out_ready at posedge clk
out_last  output  1  current word is the final word (index NWORDS-1)
out_index  output  $clog2(NWORDS)  index of current word, 0..NWORDS-1
busy  output  1  transfer in progress (state SEND)
pop_count  output  CW  number of 1 bits in the last completed snapshot
pop_valid  output  1  one-cycle pulse: pop_count just updated

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high, and overrides all other inputs.
- Reset values: state IDLE; snapshot, out_data, out_index, pop_count and the accumulator all 0; out_valid, out_last, busy and pop_valid all 0.
- States: IDLE and SEND.
- IDLE, start=1 at an edge:
  - Snapshot <= q as sampled at that edge.
  - out_data <= q[WORD-1:0]; out_index <= 0; accumulator <= 0.
  - out_valid <= 1; state -> SEND.
  - Latency: first word is valid in the cycle immediately after the start edge.
- IDLE, start=0: nothing changes.
- SEND, no handshake (out_ready=0): out_data, out_index, out_valid and out_last all hold; out_valid is never withdrawn.
- SEND, handshake on a non-final word (index < NWORDS-1):
  - accumulator += popcount(out_data).
  - out_index += 1; out_data <= snapshot word index+1, i.e. bits [(i+1)*WORD +: WORD].
  - out_valid stays 1; back-to-back words at one per cycle under continuous ready.
- SEND, handshake on the final word:
  - pop_count <= accumulator + popcount(out_data).
  - pop_valid <= 1 for exactly one cycle.
  - out_valid <= 0; state -> IDLE.
- Combinational outputs: out_last = out_valid && (out_index == NWORDS-1); busy = (state == SEND).
- start during SEND is ignored; no queuing.
- start in the IDLE cycle where pop_valid is high is accepted; back-to-back snapshots are allowed.
- Changes on q after capture have no effect on the stream.
- Reset mid-transfer: stream is aborted; out_valid is 0 after the edge; pop_valid is not pulsed; pop_count is cleared to 0. The next start begins again at index 0.
- Arithmetic: popcount is per word, zero-extended to CW bits. Maximum total is WIDTH, which fits CW bits, so no overflow is possible.
- pop_count holds its value between snapshots.

Test Plan:
- Reset held for 2 cycles with random q and start=1 -> out_valid=0, busy=0, pop_valid=0, pop_count=0, out_index=0.
- q=all ones, start pulse, out_ready=1 constant -> 16 consecutive words 0xFFFFFFFF with indices 0..15; out_last only on index 15; next cycle pop_valid=1 with pop_count=512; busy low again.
- q with only bit 0 set (rule 110 seed), start, ready=1 -> word0=0x00000001, words 1..15 = 0; pop_count=1. Then q=0xA5A5...A5 -> every word 0xA5A5A5A5, pop_count=256.
- Backpressure: capture a pattern with word k = k, toggle out_ready pseudo-randomly and change q every cycle -> each word held stable while ready=0; received words are 0..15 in order; no word dropped or duplicated; pop_count=32.
- Assert start during SEND (at index 3) -> ignored, snapshot unchanged. Assert reset at index 5 -> out_valid=0 next cycle, no pop_valid, pop_count=0. A new start restarts at index 0 with the new q.
- Assert start in the pop_valid cycle -> new capture accepted; first word valid on the next cycle; pop_count holds the previous total until the second transfer completes.
